// File: rtl/mac_pkg.sv
// Shared types and constants for the pipelined multiply-accumulate array.
package mac_pkg;

    typedef enum logic {
        MAC_FMA = 1'b0,
        MAC_ACC = 1'b1
    } mac_mode_e;

    localparam int unsigned PIPE_DEPTH = 2;

endpackage

// File: rtl/mac_lane.sv
// One arithmetic lane: S1 product/addend registers, S2 result/overflow, and the lane accumulator.
module mac_lane
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld1_i,
    input  logic             ld2_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  mac_mode_e        mode_s1_i,
    input  logic             acc_clr_s1_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = 2 * WIDTH + 1;

    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] addend_c;
    logic [SW-1:0]    sum_c;

    // Sum is one bit wider than the product so the carry into overflow is never lost
    always_comb begin
        prod_d   = prod_q;
        c_d      = c_q;
        acc_d    = acc_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        addend_c = (mode_s1_i == MAC_ACC) ? (acc_clr_s1_i ? '0 : acc_q) : c_q;
        sum_c    = SW'(prod_q) + SW'(addend_c);
        if (ld1_i) begin
            prod_d = PW'(a_i) * PW'(b_i);
            c_d    = c_i;
        end
        if (ld2_i) begin
            res_d = sum_c[WIDTH-1:0];
            ovf_d = |sum_c[SW-1:WIDTH];
            if (mode_s1_i == MAC_ACC) begin
                acc_d = sum_c[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            c_q    <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            c_q    <= c_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
        end
    end

    assign result_o   = res_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pipelined_mac_array.sv
// Multi-lane a*b+c / acc+a*b unit with a 2-stage valid/ready pipeline shared by all lanes.
module pipelined_mac_array
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic                   acc_clr,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [LANES*WIDTH-1:0] c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       overflow
);

    // vld_q[0] is the S1 valid, vld_q[1] the S2 (output) valid
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    mac_mode_e             mode_q, mode_d;
    logic                  clr_q, clr_d;
    logic                  adv1_c, adv2_c, ld1_c, ld2_c;

    always_comb begin
        adv2_c   = !vld_q[1] || out_ready;
        adv1_c   = !vld_q[0] || adv2_c;
        ld1_c    = in_valid && adv1_c;
        ld2_c    = vld_q[0] && adv2_c;
        vld_d    = vld_q;
        mode_d   = mode_q;
        clr_d    = clr_q;
        vld_d[0] = ld1_c || (vld_q[0] && !adv2_c);
        vld_d[1] = ld2_c || (vld_q[1] && !out_ready);
        if (ld1_c) begin
            mode_d = mac_mode_e'(mode);
            clr_d  = acc_clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            mode_q <= MAC_FMA;
            clr_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            clr_q  <= clr_d;
        end
    end

    assign in_ready  = adv1_c;
    assign out_valid = vld_q[1];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(.WIDTH(WIDTH)) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .ld1_i        (ld1_c),
            .ld2_i        (ld2_c),
            .a_i          (a[i*WIDTH +: WIDTH]),
            .b_i          (b[i*WIDTH +: WIDTH]),
            .c_i          (c[i*WIDTH +: WIDTH]),
            .mode_s1_i    (mode_q),
            .acc_clr_s1_i (clr_q),
            .result_o     (result[i*WIDTH +: WIDTH]),
            .overflow_o   (overflow[i])
        );
    end

endmodule

// File: tb/tb_pipelined_mac_array.sv
// Scoreboard bench for pipelined_mac_array with four 32-bit lanes and directed vectors.
module tb_pipelined_mac_array;

    localparam int unsigned W = 32;
    localparam int unsigned L = 4;

    typedef struct {
        logic [L*W-1:0] res;
        logic [L-1:0]   ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic           acc_clr;
    logic [L*W-1:0] a, b, c;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] result;
    logic [L-1:0]   overflow;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;

    pipelined_mac_array #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; holds the transaction until accepted, queuing its expectation
    task automatic send(input logic [L*W-1:0] av, input logic [L*W-1:0] bv, input logic [L*W-1:0] cv,
                        input logic md, input logic cl,
                        input logic [L*W-1:0] er, input logic [L-1:0] eo);
        exp_t e;
        bit   done;
        done     = 1'b0;
        a        = av;
        b        = bv;
        c        = cv;
        mode     = md;
        acc_clr  = cl;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = er;
                e.ovf = eo;
                sb_q.push_back(e);
                n_acc++;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        c        = 'x;
    endtask

    task automatic send1(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv,
                         input logic md, input logic cl, input logic [W-1:0] er, input logic eo);
        send({L{av}}, {L{bv}}, {L{cv}}, md, cl, {L{er}}, {L{eo}});
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int k = 0; k < 200 && !empty; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) empty = 1'b1;
        end
        if (!empty) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every output handshake and checks hold stability under stall
    initial begin : monitor
        exp_t           e;
        logic           held;
        logic [L*W-1:0] saved_r;
        logic [L-1:0]   saved_o;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && held && out_valid) begin
                check("stall_hold_result", result, saved_r);
                check("stall_hold_overflow", L*W'(overflow), L*W'(saved_o));
            end
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected no output", result);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    check("overflow", L*W'(overflow), L*W'(e.ovf));
                end
            end
            held    = rst_n && out_valid && !out_ready;
            saved_r = result;
            saved_o = overflow;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 1'b0;
        acc_clr   = 1'b0;
        a         = '0;
        b         = '0;
        c         = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", L*W'(out_valid), '0);
        check("reset_result", result, '0);
        check("reset_overflow", L*W'(overflow), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", L*W'(in_ready), L*W'(1'b1));
        @(posedge clk);
        #1;

        // FMA basics and two-cycle latency
        send1(32'd200, 32'd4, 32'd15, 1'b0, 1'b0, 32'd815, 1'b0);
        drain();
        send1(32'd7898, 32'd91, 32'd10202, 1'b0, 1'b0, 32'd728920, 1'b0);
        @(negedge clk);
        check("latency_cycle1_valid", L*W'(out_valid), '0);
        @(negedge clk);
        check("latency_cycle2_valid", L*W'(out_valid), L*W'(1'b1));
        drain();

        // Overflow boundaries, back to back
        send1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32'd1, 1'b1);
        send1(32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1);

        // Accumulate chain with an interleaved FMA that must not touch acc
        send1(32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 32'd12, 1'b0);
        send1(32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 32'd42, 1'b0);
        send1(32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0);
        send1(32'd2, 32'd2, 32'd0, 1'b1, 1'b0, 32'd46, 1'b0);

        // Independent lanes
        send({32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd10}}, {32'd3, 32'd2, 32'd1, 32'd0}, 1'b0, 1'b0,
             {32'd43, 32'd32, 32'd21, 32'd10}, 4'b0000);
        send({32'd1, 32'hFFFF_FFFF, 32'd200, 32'hFFFF_FFFF},
             {32'd1, 32'd1, 32'd4, 32'hFFFF_FFFF},
             {32'd1, 32'd1, 32'd15, 32'd0}, 1'b0, 1'b0,
             {32'd2, 32'd0, 32'd815, 32'd1}, 4'b0101);
        drain();

        // Backpressure: only two transactions fit while the output is stalled
        out_ready = 1'b0;
        acc0      = n_acc;
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    send1(W'(i), 32'd1, 32'd0, 1'b0, 1'b0, W'(i), 1'b0);
                end
            end
            begin
                repeat (5) @(negedge clk);
                check("stall_accept_count", L*W'(n_acc - acc0), L*W'(2));
                check("stall_in_ready", L*W'(in_ready), '0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with two transactions in flight
        out_ready = 1'b0;
        send1(32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 32'd81, 1'b0);
        send1(32'd8, 32'd8, 32'd0, 1'b0, 1'b0, 32'd64, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", L*W'(out_valid), '0);
        check("async_reset_result", result, '0);
        check("async_reset_overflow", L*W'(overflow), '0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send1(32'd2, 32'd3, 32'd0, 1'b1, 1'b0, 32'd6, 1'b0);
        drain();

        check("scoreboard_empty", L*W'(sb_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
